// File: rtl/alu_writeback.sv
// Writeback stage for the Ember ALU: aligns destination tags with ALU results,
// updates the architectural flags and queues register-file writes behind credit-gated issue.
module alu_writeback #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic              issue_we,
    input  logic [7:0]        issue_op,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              alu_eq,
    input  logic              alu_lt,
    input  logic              alu_gt,
    input  logic              alu_zero,
    output logic              rf_wvalid,
    input  logic              rf_wready,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [5:0]        flags,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_UCMP = 8'h08;
    localparam logic [7:0] OP_CMP  = 8'h0E;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    logic [PTR_W-1:0]  cred_q, cred_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              tag_v_q, tag_v_d;
    logic              tag_we_q, tag_we_d;
    logic [REG_AW-1:0] tag_rd_q, tag_rd_d;
    logic [7:0]        tag_op_q, tag_op_d;
    logic [5:0]        flags_q, flags_d;
    wb_entry_t         mem_q [FIFO_DEPTH];

    logic eff_we, accept, push, pop, empty, full;

    assign eff_we      = issue_we && (issue_rd != '0);
    assign issue_ready = (cred_q < PTR_W'(FIFO_DEPTH)) && !rst;
    assign accept      = issue_valid && issue_ready;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                         (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]);
    assign push        = tag_v_q && tag_we_q;
    assign pop         = rf_wvalid && rf_wready;

    assign rf_wvalid = !empty;
    assign rf_waddr  = mem_q[rd_ptr_q[IDX_W-1:0]].rd;
    assign rf_wdata  = mem_q[rd_ptr_q[IDX_W-1:0]].data;
    assign flags     = flags_q;
    assign busy      = tag_v_q || (cred_q != '0);

    // Tag pipe, credits, pointers and program-order flag update
    always_comb begin
        tag_v_d  = accept;
        tag_we_d = tag_we_q;
        tag_rd_d = tag_rd_q;
        tag_op_d = tag_op_q;
        cred_d   = cred_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        flags_d  = flags_q;

        if (accept) begin
            tag_we_d = eff_we;
            tag_rd_d = issue_rd;
            tag_op_d = issue_op;
        end

        unique case ({accept && eff_we, pop})
            2'b10:   cred_d = cred_q + PTR_W'(1);
            2'b01:   cred_d = cred_q - PTR_W'(1);
            default: cred_d = cred_q;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        // flags = {zero, gt, lt, eq, overflow, carry}
        if (tag_v_q) begin
            unique case (tag_op_q)
                OP_ADD, OP_SUB: begin
                    flags_d[0] = alu_carry;
                    flags_d[1] = alu_overflow;
                    flags_d[5] = alu_zero;
                end
                OP_UCMP, OP_CMP: begin
                    flags_d[2] = alu_eq;
                    flags_d[3] = alu_lt;
                    flags_d[4] = alu_gt;
                    flags_d[5] = alu_zero;
                end
                default: flags_d[5] = alu_zero;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cred_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            tag_v_q  <= 1'b0;
            tag_we_q <= 1'b0;
            tag_rd_q <= '0;
            tag_op_q <= '0;
            flags_q  <= '0;
        end else begin
            cred_q   <= cred_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            tag_v_q  <= tag_v_d;
            tag_we_q <= tag_we_d;
            tag_rd_q <= tag_rd_d;
            tag_op_q <= tag_op_d;
            flags_q  <= flags_d;
        end
    end

    // Payload storage needs no reset; validity lives in the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[IDX_W-1:0]] <= '{rd: tag_rd_q, data: alu_res};
        end
    end

    // Credits make a push into a full FIFO without a matching pop impossible
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule
